// File: rtl/uart_rx_word_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_word_pkg
// Shared UART definitions: receiver FSM state encoding, the default bit
// period, and the bytes-per-word constant. The 32-bit-word TX path imports
// the same package, so both directions agree on framing and word size.
//
// Optional feature macro: UART_RX_PARITY_EN. The PARITY encoding is always
// present so that both builds share one encoding. The state is only reached
// when the macro is defined.
// -----------------------------------------------------------------------------
package uart_rx_word_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

  // 50 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int BYTES_PER_WORD       = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// Single-byte UART receiver: a 2-flop input synchronizer plus the bit-level
// FSM. The framing is 8N1, or 8E1 when UART_RX_PARITY_EN is defined. Data is
// sampled at mid-bit, LSB first.
//
// Ports
//   Clk           system clock, posedge
//   rst           synchronous active-high reset
//   rx_i          asynchronous serial line, idle high
//   byte_o        received byte (complete while byte_valid_o is high)
//   byte_valid_o  combinational, high in the cycle of a good stop-bit sample
//   byte_err_o    combinational, high in the cycle of a failing stop/parity sample
//   busy_o        FSM not in IDLE
//
// The valid and error strobes are combinational on purpose. The word
// assembler registers them on the same edge that samples the stop bit, so
// o_valid and o_frame_err appear exactly one clock after that sample.
//
// Macro: UART_RX_PARITY_EN adds the even-parity PARITY state.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | line idle; a low rx_s starts a frame
// START      | wait half a bit; re-check low to reject glitches
// DATA       | sample 8 data bits, one per bit period, LSB first
// PARITY     | sample the even-parity bit (UART_RX_PARITY_EN only)
// STOP       | sample the stop bit; a high stop bit accepts the byte
// WAIT_IDLE  | framing error seen; hold until the line returns high
// -----------------------------------------------------------------------------
module uart_rx_byte
  import uart_rx_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT  // must be >= 8
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       byte_err_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TC_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] TC_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              sync_q;
  logic              rx_s_q;
  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_fail;  // a parity error was already reported for this frame

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_fail = par_err_q;
`else
  assign par_fail = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (rst) begin
      sync_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      sync_q    <= rx_i;
      rx_s_q    <= sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge Clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    byte_err_o   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d    = par_err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (!rx_s_q) state_d = ST_START;
      end

      ST_START: begin
        if (cnt_q == TC_HALF) begin
          cnt_d   = '0;
          // A line that is high again at mid start bit was a glitch. It is not an error.
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (cnt_q == TC_BIT) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == TC_BIT) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          // Even parity: data bits XOR parity bit must be zero.
          if (^{shift_q, rx_s_q}) begin
            par_err_d  = 1'b1;
            byte_err_o = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif

      ST_STOP: begin
        if (cnt_q == TC_BIT) begin
          cnt_d = '0;
          // After a parity failure the frame was already reported, so the stop
          // bit only decides where the FSM goes next.
          if (rx_s_q) begin
            state_d      = ST_IDLE;
            byte_valid_o = !par_fail;
          end else begin
            state_d    = ST_WAIT_IDLE;
            byte_err_o = !par_fail;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WAIT_IDLE: begin
        cnt_d = '0;
        // A held-low line (break) must not be read as a new start bit.
        if (rx_s_q) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign byte_o = shift_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// -----------------------------------------------------------------------------
// uart_rx_word
// UART receiver that assembles four bytes into one 32-bit word. The LSB byte
// arrives first. The host PC uses it to send velocity and setpoint words to
// the FPGA.
//
// Ports
//   Clk          system clock, posedge
//   rst          synchronous active-high reset
//   i_uart_rx    asynchronous serial line, idle high
//   o_data       last complete word, held until the next one completes
//   o_valid      one-cycle pulse when o_data updates
//   o_frame_err  one-cycle pulse on a stop-bit or parity error
//   o_busy       high while a byte is being received
//
// A partial word is dropped when the line stays idle for TIMEOUT_BITS bit
// times between bytes. This lets the host resynchronise after an aborted
// transfer.
//
// Macro: UART_RX_PARITY_EN switches framing from 8N1 to 8E1 (see uart_rx_byte).
// -----------------------------------------------------------------------------
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic        i_uart_rx,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_frame_err,
  output logic        o_busy
);

  localparam int TO_TC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W  = $clog2(TO_TC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_TC - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam int BC_W = $clog2(BYTES_PER_WORD);

  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        rx_byte_err;
  logic        rx_busy;

  logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
  // Only bytes 0..2 are buffered. Byte 3 goes straight into o_data.
  logic [23:0]     word_buf_q, word_buf_d;
  logic [31:0]     data_q, data_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .Clk          (Clk),
    .rst          (rst),
    .rx_i         (i_uart_rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_byte_valid),
    .byte_err_o   (rx_byte_err),
    .busy_o       (rx_busy)
  );

  always_ff @(posedge Clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      word_buf_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_buf_q <= word_buf_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_buf_d = word_buf_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    to_cnt_d   = to_cnt_q;

    if (rx_byte_valid) begin
      unique case (byte_cnt_q)
        2'd0:    word_buf_d[7:0]   = rx_byte;
        2'd1:    word_buf_d[15:8]  = rx_byte;
        2'd2:    word_buf_d[23:16] = rx_byte;
        default: begin
          data_d  = {rx_byte, word_buf_q};
          valid_d = 1'b1;
        end
      endcase
      // The count wraps 3 -> 0 when the word completes.
      byte_cnt_d = byte_cnt_q + 2'd1;
    end else if (rx_byte_err) begin
      err_d      = 1'b1;
      byte_cnt_d = '0;
    end

    // The byte strobes only fire while rx_busy is high. The timeout only acts
    // while rx_busy is low. So the two updates to byte_cnt_d never meet in
    // the same cycle.
    if (rx_busy || (byte_cnt_q == '0)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_d   = '0;
      byte_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = err_q;
  assign o_busy      = rx_busy;

endmodule

// File: tb/tb_uart_rx_word.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_word
// Directed bench for uart_rx_word with CLKS_PER_BIT = 16 and TIMEOUT_BITS = 40.
// Each frame the driver sends is also given to a word-level model. The model
// predicts which cycle carries o_valid or o_frame_err and what o_data becomes.
// The prediction comes from the frame start time plus the receiver latency:
// 2 synchronizer clocks, 1 clock for start detect, half a bit, then one bit
// period per remaining bit up to the last sample.
// A compare process checks every cycle against that schedule. Hand-written
// literal checks pin the model itself.
// -----------------------------------------------------------------------------
module tb_uart_rx_word;

  localparam int CPB     = 16;
  localparam int TOB     = 40;
  localparam int TO_CLKS = TOB * CPB;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Edges from the edge before the start bit to the stop-bit sample.
  localparam int LAT = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB;

  logic        Clk;
  logic        rst;
  logic        i_uart_rx;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_frame_err;
  logic        o_busy;

  uart_rx_word #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .Clk         (Clk),
    .rst         (rst),
    .i_uart_rx   (i_uart_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Model and scoreboard state
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          nv    = 0;
  int          ne    = 0;
  int          mdl_cnt   = 0;
  int          last_idle = 0;
  logic [31:0] mdl_buf   = '0;
  logic [31:0] mdl_data  = '0;
  bit          exp_v[int];
  bit          exp_e[int];
  logic [31:0] exp_d[int];

  initial begin
    bit was_rst;
    bit ev, ee;
    forever begin
      @(posedge Clk);
      cyc++;
      was_rst = (rst === 1'b1);
      @(negedge Clk);
      ev = !was_rst && exp_v.exists(cyc);
      ee = !was_rst && exp_e.exists(cyc);
      if (was_rst) mdl_data = '0;
      else if (ev) mdl_data = exp_d[cyc];
      n_vec++;
      if (o_valid !== ev || o_frame_err !== ee || o_data !== mdl_data) begin
        n_bad++;
        $display("FAIL cycle_check cyc=%0d: valid=%b want %b, frame_err=%b want %b, data=%h want %h",
                 cyc, o_valid, ev, o_frame_err, ee, o_data, mdl_data);
      end
      if (o_valid === 1'b1) nv++;
      if (o_frame_err === 1'b1) ne++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    i_uart_rx = b;
    tick(CPB);
  endtask

  // Word-level model of one frame that starts right after edge t0.
  task automatic model_frame(input int t0, input logic [7:0] data, input logic stop,
                             input logic par_flip);
    int t_stop;
    t_stop = t0 + LAT;
    if (mdl_cnt != 0 && (t0 + 3 - last_idle) >= TO_CLKS) mdl_cnt = 0;
    last_idle = t_stop;
`ifdef UART_RX_PARITY_EN
    if (par_flip) begin
      exp_e[t_stop - CPB] = 1'b1;
      mdl_cnt = 0;
      return;
    end
`else
    if (par_flip) $display("note: parity flip has no effect in the 8N1 build");
`endif
    if (!stop) begin
      exp_e[t_stop] = 1'b1;
      mdl_cnt = 0;
    end else begin
      mdl_buf[8*mdl_cnt +: 8] = data;
      mdl_cnt++;
      if (mdl_cnt == 4) begin
        exp_v[t_stop] = 1'b1;
        exp_d[t_stop] = mdl_buf;
        mdl_cnt = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop, input logic par_flip);
    model_frame(cyc, data, stop, par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^data) ^ par_flip);
`endif
    drive_bit(stop);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1, 1'b0);
  endtask

  int nv0, ne0;

  initial begin
    rst       = 1'b1;
    i_uart_rx = 1'b1;
    tick(3);
    check("reset_o_data", o_data, 32'h0);
    check("reset_o_valid", {31'b0, o_valid}, 32'h0);
    check("reset_o_frame_err", {31'b0, o_frame_err}, 32'h0);
    check("reset_o_busy", {31'b0, o_busy}, 32'h0);
    rst = 1'b0;
    tick(5);

    // Back-to-back word
    nv0 = nv; ne0 = ne;
    send_byte(8'h78, 1'b1, 1'b0);
    send_byte(8'h56, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    send_byte(8'h12, 1'b1, 1'b0);
    tick(4);
    check("word1_data", o_data, 32'h12345678);
    check("word1_valid_pulses", nv - nv0, 1);
    check("word1_no_err", ne - ne0, 0);

    // Quarter-bit glitch, then a word
    ne0 = ne;
    i_uart_rx = 1'b0;
    tick(4);
    i_uart_rx = 1'b1;
    check("glitch_busy_in_start", {31'b0, o_busy}, 32'h1);
    tick(20);
    check("glitch_back_idle", {31'b0, o_busy}, 32'h0);
    send_word(32'hDEADBEEF);
    tick(4);
    check("glitch_no_err", ne - ne0, 0);
    check("word2_data", o_data, 32'hDEADBEEF);

    // Stop-bit error, line held low, then a good word
    ne0 = ne; nv0 = nv;
    send_byte(8'hAA, 1'b0, 1'b0);
    tick(28 * CPB);
    check("break_busy_wait_idle", {31'b0, o_busy}, 32'h1);
    check("break_one_err", ne - ne0, 1);
    check("break_data_held", o_data, 32'hDEADBEEF);
    i_uart_rx = 1'b1;
    tick(2 * CPB);
    check("break_released_idle", {31'b0, o_busy}, 32'h0);
    send_word(32'h01020304);
    tick(4);
    check("word3_data", o_data, 32'h01020304);
    check("word3_one_valid", nv - nv0, 1);

    // Two bytes, idle 41 bit times, then a full word
    nv0 = nv;
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    tick(41 * CPB);
    send_word(32'hCAFEF00D);
    tick(4);
    check("timeout_word_data", o_data, 32'hCAFEF00D);
    check("timeout_one_valid", nv - nv0, 1);

    // Reset in the middle of the DATA bits of byte 2
    send_byte(8'hAB, 1'b1, 1'b0);
    send_byte(8'hCD, 1'b1, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst       = 1'b1;
    i_uart_rx = 1'b1;
    mdl_cnt   = 0;
    tick(1);
    check("midrst_o_data", o_data, 32'h0);
    check("midrst_o_valid", {31'b0, o_valid}, 32'h0);
    check("midrst_o_frame_err", {31'b0, o_frame_err}, 32'h0);
    check("midrst_o_busy", {31'b0, o_busy}, 32'h0);
    rst = 1'b0;
    tick(CPB);
    send_word(32'h88776655);
    tick(4);
    check("after_rst_word", o_data, 32'h88776655);

`ifdef UART_RX_PARITY_EN
    // Bad parity on 0x03, then a word whose first byte is 0x03 with good parity
    ne0 = ne; nv0 = nv;
    send_byte(8'h03, 1'b1, 1'b1);
    tick(4);
    check("parity_err_pulse", ne - ne0, 1);
    check("parity_no_valid", nv - nv0, 0);
    check("parity_idle_after_stop", {31'b0, o_busy}, 32'h0);
    send_word(32'h06050403);
    tick(4);
    check("parity_good_word", o_data, 32'h06050403);
`endif

    tick(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
